// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction fetch unit.
//   fetch_state_t : fetch controller FSM state encodings
//   NOP_INST      : instruction word shown at ir_inst while the queue is empty
//   fq_entry_t    : one instruction queue entry {fetch address, instruction}
//   word_align()  : clears address bits [1:0]
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      ST_FETCH   = 2'b00,   // a request may be issued
      ST_FULL    = 2'b01,   // queue holds QDEPTH entries, no request
      ST_DISCARD = 2'b10    // a stale request is outstanding, its response is dropped
   } fetch_state_t;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fq_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'd3;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Bundles the instruction-memory bus, the redirect input and the decode-side
// instruction register handshake of the fetch unit.
//   master : the fetch unit (drives imem_req/imem_aout and ir_*)
//   slave  : memory + pipeline side (drives imem_rvalid/imem_din, redirect*, ir_ready)
// -----------------------------------------------------------------------------
interface fetch_unit_if;

   logic        imem_req;
   logic [31:0] imem_aout;
   logic        imem_rvalid;
   logic [31:0] imem_din;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        ir_ready;
   logic        ir_valid;
   logic [31:0] ir_inst;
   logic [31:0] ir_pc;

   modport master (
      output imem_req, imem_aout, ir_valid, ir_inst, ir_pc,
      input  imem_rvalid, imem_din, redirect, redirect_pc, ir_ready
   );

   modport slave (
      input  imem_req, imem_aout, ir_valid, ir_inst, ir_pc,
      output imem_rvalid, imem_din, redirect, redirect_pc, ir_ready
   );

endinterface

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Circular instruction queue of QDEPTH entries (power of two).
//   i_clk    : clock
//   i_rst_n  : synchronous active-low reset (empties the queue)
//   i_push   : write i_entry at the tail (caller guarantees not full)
//   i_pop    : drop the head entry (caller guarantees not empty)
//   i_flush  : empty the queue; dominates push and pop
//   i_entry  : entry to write
//   o_valid  : queue not empty
//   o_entry  : head entry (meaningful only while o_valid)
//   o_count  : number of stored entries
// -----------------------------------------------------------------------------
module fetch_queue
   import fetch_unit_pkg::*;
#(
   parameter int QDEPTH = 2
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic                       i_flush,
   input  fq_entry_t                  i_entry,
   output logic                       o_valid,
   output fq_entry_t                  o_entry,
   output logic [$clog2(QDEPTH):0]    o_count
);

   localparam int PTR_W = $clog2(QDEPTH);

   fq_entry_t           r_mem [QDEPTH];
   logic [PTR_W-1:0]    r_rd;
   logic [PTR_W-1:0]    r_wr;
   logic [PTR_W:0]      r_cnt;

   // Pointers wrap naturally because QDEPTH is a power of two.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_flush) begin
         r_rd  <= '0;
         r_wr  <= '0;
         r_cnt <= '0;
      end else begin
         if (i_push) r_wr <= r_wr + 1'b1;
         if (i_pop)  r_rd <= r_rd + 1'b1;
         case ({i_push, i_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Storage is not reset; o_valid gates its use.
   always_ff @(posedge i_clk) begin
      if (i_push) r_mem[r_wr] <= i_entry;
   end

   assign o_valid = (r_cnt != '0);
   assign o_entry = r_mem[r_rd];
   assign o_count = r_cnt;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch: issues one word fetch at a time, queues returned words
// with their addresses and presents the queue head to decode. A redirect
// flushes the queue and restarts fetching at the new target; a response to a
// request issued before the redirect is dropped.
//   clock : sole clock, rising edge
//   reset : synchronous, active-low
//   bus   : fetch_unit_if.master (imem_*, redirect*, ir_*)
// Parameters: RESET_PC (first fetch address), QDEPTH (queue depth, 2 or 4).
// -----------------------------------------------------------------------------
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QDEPTH   = 2
) (
   input  logic            clock,
   input  logic            reset,
   fetch_unit_if.master    bus
);

   localparam int CNT_W = $clog2(QDEPTH) + 1;

   fetch_state_t        r_state;
   logic [31:0]         r_addr;     // address being / to be requested
   logic [31:0]         r_tgt;      // redirect target parked during DISCARD
   logic                r_req;

   fetch_state_t        w_nxt_state;
   logic [31:0]         w_nxt_addr;
   logic [31:0]         w_nxt_tgt;
   logic                w_push;
   logic                w_flush;
   logic                w_done;
   logic                w_pop;
   logic                w_last_slot;
   logic                w_q_valid;
   fq_entry_t           w_q_head;
   fq_entry_t           w_q_wdata;
   logic [CNT_W-1:0]    w_count;
   logic [31:0]         w_redir_addr;

   assign w_done       = r_req && bus.imem_rvalid;
   assign w_pop        = w_q_valid && bus.ir_ready;
   assign w_last_slot  = (w_count == CNT_W'(QDEPTH - 1));
   assign w_redir_addr = word_align(bus.redirect_pc);
   assign w_q_wdata    = '{pc: r_addr, inst: bus.imem_din};

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_addr  = r_addr;
      w_nxt_tgt   = r_tgt;
      w_push      = 1'b0;
      w_flush     = 1'b0;
      case (r_state)
         ST_FETCH: begin
            if (bus.redirect) begin
               w_flush = 1'b1;
               // An in-flight request must run to completion at its old
               // address; park the target until its response is dropped.
               if (r_req && !w_done) begin
                  w_nxt_state = ST_DISCARD;
                  w_nxt_tgt   = w_redir_addr;
               end else begin
                  w_nxt_addr  = w_redir_addr;
               end
            end else if (w_done) begin
               w_push     = 1'b1;
               w_nxt_addr = r_addr + 32'd4;
               if (w_last_slot && !w_pop) w_nxt_state = ST_FULL;
            end
         end
         ST_FULL: begin
            if (bus.redirect) begin
               w_flush     = 1'b1;
               w_nxt_addr  = w_redir_addr;
               w_nxt_state = ST_FETCH;
            end else if (w_pop) begin
               w_nxt_state = ST_FETCH;
            end
         end
         ST_DISCARD: begin
            if (bus.redirect) begin
               w_flush   = 1'b1;
               w_nxt_tgt = w_redir_addr;
            end
            if (w_done) begin
               w_nxt_state = ST_FETCH;
               w_nxt_addr  = bus.redirect ? w_redir_addr : r_tgt;
            end
         end
         default: begin
            w_nxt_state = ST_FETCH;
         end
      endcase
   end

   // The request is registered so it first rises the cycle after reset is
   // released, and stays up in FETCH/DISCARD until a completion.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state <= ST_FETCH;
         r_addr  <= RESET_PC;
         r_tgt   <= RESET_PC;
         r_req   <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_addr  <= w_nxt_addr;
         r_tgt   <= w_nxt_tgt;
         r_req   <= (w_nxt_state != ST_FULL);
      end
   end

   fetch_queue #(
      .QDEPTH (QDEPTH)
   ) u_queue (
      .i_clk   (clock),
      .i_rst_n (reset),
      .i_push  (w_push),
      .i_pop   (w_pop && !w_flush),
      .i_flush (w_flush),
      .i_entry (w_q_wdata),
      .o_valid (w_q_valid),
      .o_entry (w_q_head),
      .o_count (w_count)
   );

   assign bus.imem_req  = r_req;
   assign bus.imem_aout = r_addr;
   assign bus.ir_valid  = w_q_valid;
   assign bus.ir_inst   = w_q_valid ? w_q_head.inst : NOP_INST;
   assign bus.ir_pc     = w_q_valid ? w_q_head.pc   : 32'h0000_0000;

endmodule
